// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: streams a clipped rectangle to a VGA adapter at one
// pixel per cycle in row-major order, with four colour modes and abort.
module rect_fill_engine #(
    parameter int SCREEN_WIDTH  = 160,
    parameter int SCREEN_HEIGHT = 120,
    parameter int X_W           = 8,
    parameter int Y_W           = 7,
    parameter int COLOUR_W      = 3
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          mode,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      w,
    input  logic [Y_W-1:0]      h,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam logic [X_W:0] X_LAST = (X_W+1)'(SCREEN_WIDTH - 1);
    localparam logic [Y_W:0] Y_LAST = (Y_W+1)'(SCREEN_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t              state_q;
    logic [1:0]          mode_q;
    logic [X_W-1:0]      x0_q, x_end_q, x_q;
    logic [Y_W-1:0]      y0_q, y_end_q, y_q;
    logic [COLOUR_W-1:0] cin_q, idx_q, colour_q;
    logic                plot_q, busy_q, done_q;

    logic [X_W:0]        x_sum_d;
    logic [Y_W:0]        y_sum_d;
    logic [X_W-1:0]      x_end_d, x_nxt_d;
    logic [Y_W-1:0]      y_end_d, y_nxt_d, dy_d;
    logic [COLOUR_W-1:0] idx_nxt_d, colour_nxt_d;
    logic                empty_d, row_end_d, last_d, dx0_d;

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

    // End point is clipped to the screen; sums carry one extra bit so they never wrap.
    always_comb begin
        x_sum_d = {1'b0, x0} + {1'b0, w} - (X_W+1)'(1);
        y_sum_d = {1'b0, y0} + {1'b0, h} - (Y_W+1)'(1);
        x_end_d = (x_sum_d > X_LAST) ? X_LAST[X_W-1:0] : x_sum_d[X_W-1:0];
        y_end_d = (y_sum_d > Y_LAST) ? Y_LAST[Y_W-1:0] : y_sum_d[Y_W-1:0];
        empty_d = (w == '0) || (h == '0) ||
                  ({1'b0, x0} > X_LAST) || ({1'b0, y0} > Y_LAST);
    end

    always_comb begin
        row_end_d = (x_q == x_end_q);
        last_d    = row_end_d && (y_q == y_end_q);
        x_nxt_d   = row_end_d ? x0_q : x_q + X_W'(1);
        y_nxt_d   = row_end_d ? y_q + Y_W'(1) : y_q;
        idx_nxt_d = idx_q + COLOUR_W'(1);
        dy_d      = y_nxt_d - y0_q;
        dx0_d     = x_nxt_d[0] ^ x0_q[0];
        case (mode_q)
            2'd0:    colour_nxt_d = cin_q;
            2'd1:    colour_nxt_d = cin_q + idx_nxt_d;
            2'd2:    colour_nxt_d = cin_q + COLOUR_W'(dy_d);
            default: colour_nxt_d = (dx0_d ^ dy_d[0]) ? ~cin_q : cin_q;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            x_end_q  <= '0;
            y_end_q  <= '0;
            cin_q    <= '0;
            idx_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        x0_q    <= x0;
                        y0_q    <= y0;
                        cin_q   <= colour_in;
                        x_end_q <= x_end_d;
                        y_end_q <= y_end_d;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        if (empty_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= FILL;
                            x_q      <= x0;
                            y_q      <= y0;
                            colour_q <= colour_in;
                            plot_q   <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (abort || last_d) begin
                        state_q <= DONE;
                        plot_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        x_q      <= x_nxt_d;
                        y_q      <= y_nxt_d;
                        idx_q    <= idx_nxt_d;
                        colour_q <= colour_nxt_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: directed and randomized fills checked against a
// loop-based reference model of the expected pixel stream.
module tb_rect_fill_engine;

    localparam int SW = 160;
    localparam int SH = 120;

    logic       clk, reset, start, abort;
    logic [1:0] mode;
    logic [7:0] x0, w;
    logic [6:0] y0, h;
    logic [2:0] cin;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    rect_fill_engine #(
        .SCREEN_WIDTH (SW),
        .SCREEN_HEIGHT(SH),
        .X_W          (8),
        .Y_W          (7),
        .COLOUR_W     (3)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .mode     (mode),
        .x0       (x0),
        .y0       (y0),
        .w        (w),
        .h        (h),
        .colour_in(cin),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] obs_p[$];
    logic [31:0] exp_p[$];
    int          done_cyc, last_plot_cyc;
    bit          timed_out, gap, busy_bad;
    logic        post_done, post_busy, post_plot, done_busy;
    logic [31:0] hold_p;

    function automatic logic [31:0] pk(input int xx, input int yy, input int cc);
        logic [7:0] xb;
        logic [6:0] yb;
        logic [2:0] cb;
        xb = 8'(xx);
        yb = 7'(yy);
        cb = 3'(cc);
        return {8'd0, xb, 1'b0, yb, 5'd0, cb};
    endfunction

    // Reference: enumerate the clipped rectangle and apply the colour rule per pixel.
    task automatic model(input int m, input int px0, input int py0, input int pw,
                         input int ph, input int pc);
        int xe, ye, idx, c;
        exp_p.delete();
        if (pw == 0 || ph == 0 || px0 >= SW || py0 >= SH) return;
        xe = px0 + pw - 1;
        if (xe > SW - 1) xe = SW - 1;
        ye = py0 + ph - 1;
        if (ye > SH - 1) ye = SH - 1;
        idx = 0;
        for (int yy = py0; yy <= ye; yy++) begin
            for (int xx = px0; xx <= xe; xx++) begin
                case (m)
                    0:       c = pc;
                    1:       c = (pc + idx) % 8;
                    2:       c = (pc + yy - py0) % 8;
                    default: c = (((xx - px0) ^ (yy - py0)) & 1) ? (~pc) & 7 : pc;
                endcase
                exp_p.push_back(pk(xx, yy, c));
                idx++;
            end
        end
    endtask

    // Drives one start and records the output stream until done or the cycle budget runs out.
    task automatic run_fill(input int m, input int px0, input int py0, input int pw,
                            input int ph, input int pc, input int abort_after,
                            input int mid_start, input int budget);
        int cyc, np;
        obs_p.delete();
        done_cyc = -1; last_plot_cyc = -1;
        timed_out = 0; gap = 0; busy_bad = 0;
        @(negedge clk);
        mode = 2'(m); x0 = 8'(px0); y0 = 7'(py0); w = 8'(pw); h = 7'(ph); cin = 3'(pc);
        start = 1'b1; abort = 1'b0;
        cyc = 0; np = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; abort = 1'b0;
            if (plot) begin
                if (np > 0 && last_plot_cyc != cyc - 1) gap = 1;
                if (!busy || done) busy_bad = 1;
                obs_p.push_back({8'd0, x, 1'b0, y, 5'd0, colour});
                np++;
                last_plot_cyc = cyc;
            end
            if (done) begin
                done_cyc = cyc; done_busy = busy;
                hold_p = {8'd0, x, 1'b0, y, 5'd0, colour};
                break;
            end
            if (cyc >= budget) begin
                timed_out = 1;
                break;
            end
            if (abort_after > 0 && np == abort_after) abort = 1'b1;
            if (mid_start > 0 && np == mid_start) start = 1'b1;
            if (mid_start > 0) begin
                mode = 2'($urandom); x0 = 8'($urandom); y0 = 7'($urandom);
                w = 8'($urandom); h = 7'($urandom); cin = 3'($urandom);
            end
        end
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL fill_timeout: no done after %0d cycles, required done within budget", cyc);
        end else begin
            @(negedge clk);
            post_done = done; post_busy = busy; post_plot = plot;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({plot, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: plot/busy/done=%b required 000", {plot, busy, done});
        end
        checks++;
        if ({x, y, colour} !== 18'd0) begin
            errors++;
            $display("FAIL reset_pixel: x=%h y=%h colour=%h required 0", x, y, colour);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({plot, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL idle_after_reset: plot/busy/done=%b required 000", {plot, busy, done});
            end
        end
    endtask

    task automatic test_full_screen();
        int bad;
        run_fill(0, 0, 0, 160, 120, 2, 0, 0, 19400);
        model(0, 0, 0, 160, 120, 2);
        checks++;
        if (obs_p.size() != 19200) begin
            errors++;
            $display("FAIL full_count: got %0d plots required 19200", obs_p.size());
        end
        bad = 0;
        for (int i = 0; i < obs_p.size() && i < exp_p.size(); i++) begin
            checks++;
            if (obs_p[i] !== exp_p[i]) begin
                errors++;
                if (bad < 5) $display("FAIL full_pixel %0d: got %h required %h", i, obs_p[i], exp_p[i]);
                bad++;
            end
        end
        if (obs_p.size() == 19200) begin
            checks++;
            if (obs_p[0] !== pk(0, 0, 2) || obs_p[19199] !== pk(159, 119, 2)) begin
                errors++;
                $display("FAIL full_ends: first %h last %h required %h %h",
                         obs_p[0], obs_p[19199], pk(0, 0, 2), pk(159, 119, 2));
            end
        end
        checks++;
        if (done_cyc != 19201 || gap) begin
            errors++;
            $display("FAIL full_done: done at cycle %0d gap=%0d required 19201 gap=0", done_cyc, gap);
        end
    endtask

    task automatic test_clipping();
        int m, c, outside;
        m = $urandom_range(0, 3);
        c = $urandom_range(0, 7);
        run_fill(m, 150, 115, 20, 10, c, 0, 0, 200);
        model(m, 150, 115, 20, 10, c);
        checks++;
        if (obs_p.size() != 50) begin
            errors++;
            $display("FAIL clip_count: got %0d plots required 50", obs_p.size());
        end
        outside = 0;
        foreach (obs_p[i]) if (obs_p[i][23:16] > 159 || obs_p[i][14:8] > 119) outside++;
        checks++;
        if (outside != 0) begin
            errors++;
            $display("FAIL clip_bounds: got %0d off-screen pixels required 0", outside);
        end
        for (int i = 0; i < obs_p.size() && i < exp_p.size(); i++) begin
            checks++;
            if (obs_p[i] !== exp_p[i]) begin
                errors++;
                $display("FAIL clip_pixel %0d: got %h required %h", i, obs_p[i], exp_p[i]);
            end
        end
    endtask

    task automatic test_mode1_wrap();
        int ec[9] = '{6, 7, 0, 1, 2, 3, 4, 5, 6};
        run_fill(1, 0, 0, 3, 3, 6, 0, 0, 50);
        checks++;
        if (obs_p.size() != 9) begin
            errors++;
            $display("FAIL wrap_count: got %0d plots required 9", obs_p.size());
        end
        for (int i = 0; i < obs_p.size() && i < 9; i++) begin
            checks++;
            if (obs_p[i] !== pk(i % 3, i / 3, ec[i])) begin
                errors++;
                $display("FAIL wrap_pixel %0d: got %h required %h", i, obs_p[i], pk(i % 3, i / 3, ec[i]));
            end
        end
    endtask

    task automatic test_degenerate_mode3();
        int dx[3] = '{5, 200, 0};
        int dy[3] = '{5, 0, 120};
        int dw[3] = '{0, 5, 5};
        int dh[3] = '{5, 5, 5};
        int ec[4] = '{1, 6, 6, 1};
        for (int k = 0; k < 3; k++) begin
            run_fill(0, dx[k], dy[k], dw[k], dh[k], 3, 0, 0, 20);
            checks++;
            if (obs_p.size() != 0 || done_cyc != 1 || done_busy !== 1'b1) begin
                errors++;
                $display("FAIL degenerate_%0d: plots=%0d done_cycle=%0d busy=%b required 0 1 1",
                         k, obs_p.size(), done_cyc, done_busy);
            end
        end
        run_fill(3, 10, 20, 2, 2, 1, 0, 0, 20);
        checks++;
        if (obs_p.size() != 4) begin
            errors++;
            $display("FAIL mode3_count: got %0d plots required 4", obs_p.size());
        end
        for (int i = 0; i < obs_p.size() && i < 4; i++) begin
            checks++;
            if (obs_p[i] !== pk(10 + i % 2, 20 + i / 2, ec[i])) begin
                errors++;
                $display("FAIL mode3_pixel %0d: got %h required %h", i, obs_p[i],
                         pk(10 + i % 2, 20 + i / 2, ec[i]));
            end
        end
    endtask

    task automatic test_abort();
        int aw[3] = '{8, 5, 4};
        int ah[3] = '{3, 1, 2};
        for (int k = 0; k < 3; k++) begin
            run_fill(1, 30, 40, aw[k], ah[k], 4, 5, 0, 50);
            model(1, 30, 40, aw[k], ah[k], 4);
            checks++;
            if (obs_p.size() != 5 || done_cyc != 6) begin
                errors++;
                $display("FAIL abort_%0d: plots=%0d done_cycle=%0d required 5 6", k, obs_p.size(), done_cyc);
            end
            for (int i = 0; i < obs_p.size() && i < 5; i++) begin
                checks++;
                if (obs_p[i] !== exp_p[i]) begin
                    errors++;
                    $display("FAIL abort_pixel %0d: got %h required %h", i, obs_p[i], exp_p[i]);
                end
            end
            checks++;
            if (post_done !== 1'b0 || post_busy !== 1'b0 || post_plot !== 1'b0 || hold_p !== exp_p[4]) begin
                errors++;
                $display("FAIL abort_after: done=%b busy=%b plot=%b hold=%h required 0 0 0 %h",
                         post_done, post_busy, post_plot, hold_p, exp_p[4]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        run_fill(1, 20, 30, 6, 4, 5, 0, 3, 100);
        model(1, 20, 30, 6, 4, 5);
        checks++;
        if (obs_p.size() != 24 || done_cyc != 25) begin
            errors++;
            $display("FAIL midstart_count: plots=%0d done_cycle=%0d required 24 25", obs_p.size(), done_cyc);
        end
        for (int i = 0; i < obs_p.size() && i < exp_p.size(); i++) begin
            checks++;
            if (obs_p[i] !== exp_p[i]) begin
                errors++;
                $display("FAIL midstart_pixel %0d: got %h required %h", i, obs_p[i], exp_p[i]);
            end
        end
    endtask

    task automatic test_reset_midfill();
        int np, cyc;
        bit saw;
        @(negedge clk);
        mode = 2'd1; x0 = 8'd5; y0 = 7'd5; w = 8'd10; h = 7'd4; cin = 3'd3; start = 1'b1;
        np = 0; cyc = 0;
        while (np < 7 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (plot) np++;
        end
        checks++;
        if (np != 7) begin
            errors++;
            $display("FAIL rstfill_plots: got %0d plots required 7", np);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({plot, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL rstfill_flags: plot/busy/done=%b required 000", {plot, busy, done});
        end
        checks++;
        if ({x, y, colour} !== 18'd0) begin
            errors++;
            $display("FAIL rstfill_pixel: x=%h y=%h colour=%h required 0", x, y, colour);
        end
        saw = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) saw = 1;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy || plot) saw = 1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL rstfill_nodone: activity seen after reset=1 required none");
        end
        run_fill(2, 0, 100, 12, 30, 7, 0, 0, 400);
        model(2, 0, 100, 12, 30, 7);
        checks++;
        if (obs_p.size() != 240 || done_cyc != 241) begin
            errors++;
            $display("FAIL rstfill_fresh: plots=%0d done_cycle=%0d required 240 241", obs_p.size(), done_cyc);
        end
        for (int i = 0; i < obs_p.size() && i < exp_p.size(); i++) begin
            checks++;
            if (obs_p[i] !== exp_p[i]) begin
                errors++;
                $display("FAIL rstfill_pixel %0d: got %h required %h", i, obs_p[i], exp_p[i]);
            end
        end
    endtask

    task automatic test_back_to_back_random();
        int m, px0, py0, pw, ph, pc, ab, ms, eff;
        for (int it = 0; it < 30; it++) begin
            m = $urandom_range(0, 3);
            px0 = $urandom_range(0, 175);
            py0 = $urandom_range(0, 125);
            pw = $urandom_range(0, 24);
            ph = $urandom_range(0, 16);
            pc = $urandom_range(0, 7);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
            ms = (ab == 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
            run_fill(m, px0, py0, pw, ph, pc, ab, ms, 500);
            model(m, px0, py0, pw, ph, pc);
            eff = exp_p.size();
            if (ab > 0 && ab < eff) eff = ab;
            checks++;
            if (obs_p.size() != eff || done_cyc != eff + 1) begin
                errors++;
                $display("FAIL rand_%0d_count: plots=%0d done_cycle=%0d required %0d %0d",
                         it, obs_p.size(), done_cyc, eff, eff + 1);
            end
            for (int i = 0; i < obs_p.size() && i < eff; i++) begin
                checks++;
                if (obs_p[i] !== exp_p[i]) begin
                    errors++;
                    $display("FAIL rand_%0d_pixel %0d: got %h required %h", it, i, obs_p[i], exp_p[i]);
                end
            end
            checks++;
            if (gap || busy_bad || done_busy !== 1'b1 || post_done !== 1'b0 || post_busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_%0d_flags: gap=%0d busy_bad=%0d done_busy=%b post_done=%b post_busy=%b required 0 0 1 0 0",
                         it, gap, busy_bad, done_busy, post_done, post_busy);
            end
            if (eff > 0) begin
                checks++;
                if (hold_p !== exp_p[eff-1]) begin
                    errors++;
                    $display("FAIL rand_%0d_hold: got %h required %h", it, hold_p, exp_p[eff-1]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        mode = '0; x0 = '0; y0 = '0; w = '0; h = '0; cin = '0;
        test_reset();
        test_full_screen();
        test_clipping();
        test_mode1_wrap();
        test_degenerate_mode3();
        test_abort();
        test_start_while_busy();
        test_reset_midfill();
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rect_fill_engine.md
RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

Interface
REQ-001 Parameter SCREEN_WIDTH, default 160, horizontal pixel count; x range 0..SCREEN_WIDTH-1.
REQ-002 Parameter SCREEN_HEIGHT, default 120, vertical pixel count; y range 0..SCREEN_HEIGHT-1.
REQ-003 Parameter X_W, default 8, width of all x-related ports.
REQ-004 Parameter Y_W, default 7, width of all y-related ports.
REQ-005 Parameter COLOUR_W, default 3, colour width.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-007 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 start  input  1  request a fill; sampled only in IDLE.
REQ-010 abort  input  1  terminate the current fill; sampled only in FILL.
REQ-011 mode  input  2  fill mode; latched on accepted start.
REQ-012 x0  input  X_W  rectangle left column; latched on accepted start.
REQ-013 y0  input  Y_W  rectangle top row; latched on accepted start.
REQ-014 w  input  X_W  rectangle width in pixels; latched on accepted start.
REQ-015 h  input  Y_W  rectangle height in pixels; latched on accepted start.
REQ-016 colour_in  input  COLOUR_W  base colour; latched on accepted start.
REQ-017 x  output  X_W  pixel column, registered.
REQ-018 y  output  Y_W  pixel row, registered.
REQ-019 colour  output  COLOUR_W  pixel colour, registered.
REQ-020 plot  output  1  write strobe to the VGA adapter, registered.
REQ-021 busy  output  1  high in FILL and DONE.
REQ-022 done  output  1  single-cycle completion pulse, high only in DONE.

Function
REQ-023 The FSM SHALL have exactly three states.
- IDLE: waiting for start.
- FILL: one pixel per cycle.
- DONE: one cycle, then back to IDLE.
REQ-024 Start accepted (start=1 at an edge while IDLE) SHALL latch mode, x0, y0, colour_in and compute the clipped end point.
- x_end = min(x0+w-1, SCREEN_WIDTH-1).
- y_end = min(y0+h-1, SCREEN_HEIGHT-1).
- Sums SHALL be computed one bit wider than the operand, so no wrap occurs.
REQ-025 If w=0, h=0, x0>=SCREEN_WIDTH or y0>=SCREEN_HEIGHT, an accepted start SHALL go IDLE->DONE with no plot cycle.
REQ-026 Otherwise an accepted start SHALL go IDLE->FILL, with first-pixel values registered on that same edge.
- x=x0, y=y0, plot=1, so plot is high in the first cycle after the accepting edge.
REQ-027 FILL SHALL visit pixels in row-major order, one per cycle, plot held continuously high.
- x increments each cycle.
- At x=x_end, x reloads x0 and y increments.
REQ-028 After the pixel (x_end, y_end) is output, the next edge SHALL enter DONE with plot=0.
- Plot-high cycle count = (x_end-x0+1)*(y_end-y0+1).
REQ-029 In DONE, done=1 and busy=1 for exactly one cycle; the next edge SHALL return to IDLE.
REQ-030 start SHALL be ignored in FILL and DONE; latched parameters SHALL not change mid-fill.
REQ-031 abort=1 at an edge in FILL SHALL enter DONE on that edge.
- plot=0 from then on; no further pixels are output.
- If abort and the last-pixel transition coincide, the behaviour is identical: DONE.
REQ-032 Colour per mode, all arithmetic modulo 2^COLOUR_W:
- mode 0: colour_in.
- mode 1: colour_in + pixel index, where the index counts from 0 at the first pixel.
- mode 2: colour_in + (y-y0).
- mode 3: colour_in when (x-x0)^(y-y0) has bit 0 clear, otherwise the bitwise inverse of colour_in.
REQ-033 In IDLE and DONE, x, y and colour SHALL hold their last values and plot SHALL be 0.

Reset
REQ-034 reset=1 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE;
- plot=0, busy=0, done=0;
- x=0, y=0, colour=0.
REQ-035 Reset during FILL SHALL abandon the fill; no done pulse SHALL be produced.
REQ-036 After reset release, the block SHALL remain in IDLE until an accepted start.

Verification
REQ-037 Full-screen solid fill. Stimulus: x0=0, y0=0, w=160, h=120, mode=0, colour_in=010. Response:
- 19200 contiguous plot cycles, all colour=010;
- first pixel (0,0), last pixel (159,119);
- done=1 in the following cycle.
REQ-038 Clipping. Stimulus: x0=150, y0=115, w=20, h=10. Response:
- exactly 50 plots, x 150..159, y 115..119;
- no x>159 and no y>119.
REQ-039 Mode 1 wrap. Stimulus: x0=0, y0=0, w=3, h=3, colour_in=110. Response:
- colour sequence 6,7,0,1,2,3,4,5,6;
- x sequence 0,1,2 repeating per row.
REQ-040 Degenerate sizes and mode 3. Stimulus: w=0 with h=5, then separately x0=200. Response:
- zero plot cycles in both cases;
- done pulse in the cycle after start.
Then a mode 3 2x2 fill with colour_in=001 SHALL output 001,110,110,001.
REQ-041 Abort and start-while-busy. Stimulus: abort after 5 plots; a start pulse in the middle of a fill. Response:
- abort: exactly 5 plots, then done=1 next cycle;
- mid-fill start: no effect on the pixel count.
REQ-042 Reset mid-fill. Stimulus: reset asserted asynchronously after 7 plots. Response:
- plot, busy and done drop to 0 before the next edge; x=0, y=0, colour=0;
- no done pulse;
- the next accepted start produces a complete fresh fill.
